// File: rtl/mod_sub_pipe.sv
// rtl/mod_sub_pipe.sv - two-stage pipelined modular subtractor r = (a - b) mod Q
// Defining MOD_SUB_RANGE_CHK_EN adds an input range flag carried to out_err.
module mod_sub_pipe #(
   parameter int DATA_WID = 12,
   parameter int Q        = 3329
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_WID-1:0] in_a,
   input  logic [DATA_WID-1:0] in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_WID-1:0] out_r,
   output logic                out_err
);
   localparam logic [DATA_WID-1:0] Q_W = DATA_WID'(Q);

   logic                s1_valid;
   logic                s2_valid;
   logic                s1_adv;
   logic                s2_adv;
   logic [DATA_WID:0]   s1_diff;
   logic [DATA_WID:0]   diff_c;
   logic [DATA_WID-1:0] s2_r;
   logic [DATA_WID-1:0] fix_c;

   // An empty stage always advances, so bubbles collapse under a stalled output.
   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   assign diff_c = {1'b0, in_a} - {1'b0, in_b};
   assign fix_c  = s1_diff[DATA_WID] ? (s1_diff[DATA_WID-1:0] + Q_W)
                                     : s1_diff[DATA_WID-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_diff  <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_diff <= diff_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_r     <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_r <= fix_c;
         end
      end
   end

   assign out_valid = s2_valid;
   assign out_r     = s2_r;

`ifdef MOD_SUB_RANGE_CHK_EN
   logic s1_err;
   logic s2_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_err <= 1'b0;
      end else if (s1_adv && in_valid) begin
         s1_err <= (in_a >= Q_W) || (in_b >= Q_W);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_err <= 1'b0;
      end else if (s2_adv && s1_valid) begin
         s2_err <= s1_err;
      end
   end

   assign out_err = s2_err && s2_valid;
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_sub_pipe.sv
// tb/tb_mod_sub_pipe.sv - self-checking bench for mod_sub_pipe
// Directed vector table plus streaming, backpressure, random handshake and reset sequences.
module tb_mod_sub_pipe;
   localparam int W  = 12;
   localparam int QM = 3329;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_r;
   logic         out_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int a;
      int b;
      int r;
   } vec_t;
   vec_t vecs[8];

   int sa[$];
   int sb[$];
   int exp_r[$];
   int exp_e[$];

   mod_sub_pipe #(.DATA_WID(W), .Q(QM)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   function automatic int ref_sub(input int a, input int b);
      return (a - b + QM) % QM;
   endfunction

   function automatic int ref_err(input int a, input int b);
`ifdef MOD_SUB_RANGE_CHK_EN
      return (a >= QM || b >= QM) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   // Plays sa/sb through the DUT; mode 1 randomises the matching handshake signal.
   task automatic run_stream(input string name, input int in_mode, input int out_mode,
                             input int stall, input bit chk_rate);
      int total = sa.size();
      int idx = 0;
      int rcv = 0;
      int cyc = 0;
      int got;
      exp_r.delete();
      exp_e.delete();
      while (rcv < total && cyc < 20000) begin
         @(negedge clk);
         if (idx < total && (in_mode == 0 || $urandom_range(0, 1) == 1)) begin
            in_valid = 1'b1;
            in_a = W'(sa[idx]);
            in_b = W'(sb[idx]);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = (cyc < stall) ? 1'b0 : (out_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         if (stall > 0 && cyc >= 2 && cyc < stall) begin
            check({name, " stall in_ready"}, in_ready, 0);
            check({name, " stall out_r"}, out_r, exp_r[0]);
         end
         if (out_valid && out_ready) begin
            if (exp_r.size() == 0) begin
               check({name, " spurious output"}, 1, 0);
            end else begin
               got = exp_e.pop_front();
               if (got == 0) check({name, " out_r"}, out_r, exp_r[0]);
               void'(exp_r.pop_front());
               check({name, " out_err"}, out_err, got);
            end
            rcv++;
         end
         if (in_valid && in_ready) begin
            exp_r.push_back(ref_sub(sa[idx], sb[idx]));
            exp_e.push_back(ref_err(sa[idx], sb[idx]));
            idx++;
         end
         cyc++;
         @(posedge clk);
      end
      check({name, " results received"}, rcv, total);
      if (chk_rate) check({name, " cycles"}, cyc, total + 2);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check({name, " drained"}, out_valid, 0);
      sa.delete();
      sb.delete();
   endtask

   initial begin
      vecs[0] = '{5, 3, 2};
      vecs[1] = '{3, 5, 3327};
      vecs[2] = '{0, 3328, 1};
      vecs[3] = '{3328, 3328, 0};
      vecs[4] = '{3328, 0, 3328};
      vecs[5] = '{1234, 1234, 0};
      vecs[6] = '{100, 2000, 1429};
      vecs[7] = '{2000, 100, 1900};

      #1;
      check("reset out_valid", out_valid, 0);
      check("reset out_r", out_r, 0);
      check("reset out_err", out_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post-reset in_ready", in_ready, 1);

      // Single operations: result appears two edges after the accepting edge.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_a = W'(vecs[i].a);
         in_b = W'(vecs[i].b);
         out_ready = 1'b1;
         #1;
         check($sformatf("vec%0d in_ready", i), in_ready, 1);
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         check($sformatf("vec%0d early out_valid", i), out_valid, 0);
         @(negedge clk);
         #1;
         check($sformatf("vec%0d out_valid", i), out_valid, 1);
         check($sformatf("vec%0d out_r", i), out_r, vecs[i].r);
         check($sformatf("vec%0d out_err", i), out_err, 0);
      end
      @(negedge clk);

      for (int i = 0; i < 1000; i++) begin
         sa.push_back($urandom_range(0, QM - 1));
         sb.push_back($urandom_range(0, QM - 1));
      end
      run_stream("stream", 0, 0, 0, 1'b1);

      sa = '{10, 20, 7};
      sb = '{20, 10, 7};
      run_stream("backpressure", 0, 0, 7, 1'b0);

      for (int i = 0; i < 300; i++) begin
         sa.push_back($urandom_range(0, QM - 1));
         sb.push_back($urandom_range(0, QM - 1));
      end
      run_stream("random", 1, 1, 0, 1'b0);

`ifdef MOD_SUB_RANGE_CHK_EN
      sa = '{1, 3329, 2, 4, 5};
      sb = '{0, 0, 0, 4000, 1};
      run_stream("range", 0, 0, 0, 1'b0);
`endif

      // Reset mid-stream discards everything in flight.
      @(negedge clk);
      in_valid = 1'b1;
      in_a = W'(50);
      in_b = W'(60);
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("pre-reset full", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid reset out_valid", out_valid, 0);
      check("mid reset out_r", out_r, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("after reset in_ready", in_ready, 1);
      repeat (3) begin
         @(negedge clk);
         #1;
         check("after reset no stale data", out_valid, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
